// File: rtl/hc_pkg.sv
// Shared definitions for the HardCloud stream sequencer: CSR map, control codes,
// FSM state encoding and the read-response FIFO payload.
package hc_pkg;

  localparam int unsigned HC_LINE_W = 512;
  localparam int unsigned HC_TAG_W  = 16;
  localparam int unsigned HC_CNT_W  = 16;
  localparam int unsigned HC_LANES  = 16;

  // MMIO CSR byte offsets
  localparam logic [15:0] HC_DSM_BASE    = 16'h0110;
  localparam logic [15:0] HC_CONTROL     = 16'h0118;
  localparam logic [15:0] HC_BUFFER_SIZE = 16'h0120;
  localparam logic [15:0] HC_BUFFER_BASE = 16'h0128;

  localparam logic [31:0] HC_CONTROL_ASSERT_RST   = 32'h0000_0000;
  localparam logic [31:0] HC_CONTROL_DEASSERT_RST = 32'h0000_0001;
  localparam logic [31:0] HC_CONTROL_START        = 32'h0000_0003;
  localparam logic [31:0] HC_CONTROL_STOP         = 32'h0000_0007;

  localparam logic [HC_LINE_W-1:0] HC_FLAG_DONE = 512'h1;

  typedef enum logic [2:0] {
    IDLE,
    RUN,
    DRAIN,
    FLAG,
    DONE
  } t_hc_state;

  typedef struct packed {
    logic [HC_TAG_W-1:0]  mdata;
    logic [HC_LINE_W-1:0] data;
  } t_rd_entry;

  // Adds k to every 32-bit lane, each lane wrapping independently
  function automatic logic [HC_LINE_W-1:0] hc_lane_add(input logic [HC_LINE_W-1:0] line,
                                                        input logic [31:0] k);
    logic [HC_LINE_W-1:0] r;
    r = '0;
    for (int i = 0; i < int'(HC_LANES); i++) begin
      r[32*i +: 32] = line[32*i +: 32] + k;
    end
    return r;
  endfunction

endpackage

// File: rtl/hc_stream_ctrl_if.sv
// CCI-P style read/write request and response channels between the sequencer
// (master) and the registered sTx/sRx shim (slave).
interface hc_stream_ctrl_if #(
  parameter int unsigned ADDR_W = 42
);
  import hc_pkg::*;

  logic                  c0_alm_full;
  logic                  c1_alm_full;
  logic                  rd_req_valid;
  logic [ADDR_W-1:0]     rd_req_addr;
  logic [HC_TAG_W-1:0]   rd_req_mdata;
  logic                  rd_rsp_valid;
  logic [HC_TAG_W-1:0]   rd_rsp_mdata;
  logic [HC_LINE_W-1:0]  rd_rsp_data;
  logic                  wr_req_valid;
  logic [ADDR_W-1:0]     wr_req_addr;
  logic [HC_LINE_W-1:0]  wr_req_data;
  logic                  wr_rsp_valid;

  modport master (
    input  c0_alm_full, c1_alm_full,
    input  rd_rsp_valid, rd_rsp_mdata, rd_rsp_data, wr_rsp_valid,
    output rd_req_valid, rd_req_addr, rd_req_mdata,
    output wr_req_valid, wr_req_addr, wr_req_data
  );

  modport slave (
    output c0_alm_full, c1_alm_full,
    output rd_rsp_valid, rd_rsp_mdata, rd_rsp_data, wr_rsp_valid,
    input  rd_req_valid, rd_req_addr, rd_req_mdata,
    input  wr_req_valid, wr_req_addr, wr_req_data
  );

endinterface

// File: rtl/hc_sync_fifo.sv
// Single-clock FIFO with show-ahead read data; simultaneous push and pop keep
// occupancy unchanged, also when full.
module hc_sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           push_i,
  input  logic [WIDTH-1:0]               wdata_i,
  input  logic                           pop_i,
  output logic [WIDTH-1:0]               rdata_o,
  output logic                           full_o,
  output logic                           empty_o,
  output logic [$clog2(DEPTH+1)-1:0]     count_o
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q, count_d;
  logic             full_q, empty_q;
  logic             do_push, do_pop;

  assign do_pop  = pop_i && !empty_q;
  assign do_push = push_i && (!full_q || do_pop);
  assign count_d = count_q + CW'(do_push) - CW'(do_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      if (do_push) wr_ptr_q <= (wr_ptr_q == AW'(DEPTH - 1)) ? '0 : wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= (rd_ptr_q == AW'(DEPTH - 1)) ? '0 : rd_ptr_q + AW'(1);
      count_q <= count_d;
      full_q  <= (count_d == CW'(DEPTH));
      empty_q <= (count_d == '0);
    end
  end

  // Storage needs no reset; validity is tracked by the pointers
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign full_o  = full_q;
  assign empty_o = empty_q;
  assign count_o = count_q;

endmodule

// File: rtl/hc_stream_ctrl.sv
// HardCloud stream sequencer: reads N source lines, adds a constant per 32-bit
// lane, writes them to the destination, then posts a completion flag to DSM+1.
module hc_stream_ctrl
  import hc_pkg::*;
#(
  parameter int unsigned MAX_OUTSTANDING = 8,
  parameter logic [31:0] ADD_CONST       = 32'd10,
  parameter int unsigned ADDR_W          = 42
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [ADDR_W-1:0]    cfg_src_addr,
  input  logic [ADDR_W-1:0]    cfg_dst_addr,
  input  logic [ADDR_W-1:0]    cfg_dsm_addr,
  input  logic [15:0]          cfg_num_lines,
  input  logic                 cfg_start,
  input  logic                 cfg_stop,
  hc_stream_ctrl_if.master     bus,
  output logic                 busy,
  output logic                 done
);

  localparam int unsigned FIFO_W = $bits(t_rd_entry);
  localparam int unsigned FCW    = $clog2(MAX_OUTSTANDING + 1);

  t_hc_state               state_q, state_d;
  logic [ADDR_W-1:0]       src_q, src_d, dst_q, dst_d, dsm_q, dsm_d;
  logic [HC_CNT_W-1:0]     num_q, num_d;
  logic [HC_CNT_W-1:0]     rd_issued_q, rd_issued_d;
  logic [HC_CNT_W-1:0]     wr_issued_q, wr_issued_d;
  logic [HC_CNT_W-1:0]     wr_acked_q, wr_acked_d;
  logic [HC_CNT_W-1:0]     in_flight;

  logic                    rd_req_valid_q, rd_req_valid_d;
  logic [ADDR_W-1:0]       rd_req_addr_q, rd_req_addr_d;
  logic [HC_TAG_W-1:0]     rd_req_mdata_q, rd_req_mdata_d;
  logic                    wr_req_valid_q, wr_req_valid_d;
  logic [ADDR_W-1:0]       wr_req_addr_q, wr_req_addr_d;
  logic [HC_LINE_W-1:0]    wr_req_data_q, wr_req_data_d;
  logic                    busy_q, busy_d, done_q, done_d;

  logic                    fifo_push, fifo_pop, fifo_flush;
  logic                    fifo_full, fifo_empty;
  logic [FCW-1:0]          fifo_count;
  t_rd_entry               fifo_wdata, fifo_rdata;

  assign in_flight  = rd_issued_q - wr_issued_q;
  // Responses arriving in IDLE are leftovers from an aborted run
  assign fifo_push  = bus.rd_rsp_valid && (state_q != IDLE);
  assign fifo_flush = (state_q == IDLE) && cfg_start;
  assign fifo_wdata = t_rd_entry'{mdata: bus.rd_rsp_mdata, data: bus.rd_rsp_data};

  hc_sync_fifo #(
    .WIDTH (FIFO_W),
    .DEPTH (MAX_OUTSTANDING)
  ) u_fifo (
    .clk     (clk),
    .rst     (reset || fifo_flush),
    .push_i  (fifo_push),
    .wdata_i (fifo_wdata),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  always_comb begin
    state_d        = state_q;
    src_d          = src_q;
    dst_d          = dst_q;
    dsm_d          = dsm_q;
    num_d          = num_q;
    rd_issued_d    = rd_issued_q;
    wr_issued_d    = wr_issued_q;
    wr_acked_d     = wr_acked_q;
    rd_req_valid_d = 1'b0;
    rd_req_addr_d  = rd_req_addr_q;
    rd_req_mdata_d = rd_req_mdata_q;
    wr_req_valid_d = 1'b0;
    wr_req_addr_d  = wr_req_addr_q;
    wr_req_data_d  = wr_req_data_q;
    fifo_pop       = 1'b0;

    if (state_q != IDLE && bus.wr_rsp_valid) wr_acked_d = wr_acked_q + HC_CNT_W'(1);

    // Data writes drain the FIFO in both RUN and DRAIN; c1 is idle otherwise
    if ((state_q == RUN || state_q == DRAIN) && !fifo_empty && !bus.c1_alm_full) begin
      fifo_pop       = 1'b1;
      wr_req_valid_d = 1'b1;
      wr_req_addr_d  = dst_q + ADDR_W'(fifo_rdata.mdata);
      wr_req_data_d  = hc_lane_add(fifo_rdata.data, ADD_CONST);
      wr_issued_d    = wr_issued_q + HC_CNT_W'(1);
    end

    case (state_q)
      IDLE: begin
        if (cfg_start) begin
          src_d       = cfg_src_addr;
          dst_d       = cfg_dst_addr;
          dsm_d       = cfg_dsm_addr;
          num_d       = cfg_num_lines;
          rd_issued_d = '0;
          wr_issued_d = '0;
          wr_acked_d  = '0;
          state_d     = (cfg_num_lines == '0) ? FLAG : RUN;
        end
      end
      RUN: begin
        if (rd_issued_q == num_q) begin
          state_d = DRAIN;
        end else if (!bus.c0_alm_full && in_flight < HC_CNT_W'(MAX_OUTSTANDING)) begin
          rd_req_valid_d = 1'b1;
          rd_req_addr_d  = src_q + ADDR_W'(rd_issued_q);
          rd_req_mdata_d = rd_issued_q;
          rd_issued_d    = rd_issued_q + HC_CNT_W'(1);
        end
      end
      DRAIN: begin
        if (wr_issued_q == num_q && wr_acked_q == num_q) state_d = FLAG;
      end
      FLAG: begin
        if (!bus.c1_alm_full) begin
          wr_req_valid_d = 1'b1;
          wr_req_addr_d  = dsm_q + ADDR_W'(1);
          wr_req_data_d  = HC_FLAG_DONE;
          state_d        = DONE;
        end
      end
      DONE: begin
        if (cfg_stop) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE) && (state_d != DONE);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      src_q          <= '0;
      dst_q          <= '0;
      dsm_q          <= '0;
      num_q          <= '0;
      rd_issued_q    <= '0;
      wr_issued_q    <= '0;
      wr_acked_q     <= '0;
      rd_req_valid_q <= 1'b0;
      rd_req_addr_q  <= '0;
      rd_req_mdata_q <= '0;
      wr_req_valid_q <= 1'b0;
      wr_req_addr_q  <= '0;
      wr_req_data_q  <= '0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      src_q          <= src_d;
      dst_q          <= dst_d;
      dsm_q          <= dsm_d;
      num_q          <= num_d;
      rd_issued_q    <= rd_issued_d;
      wr_issued_q    <= wr_issued_d;
      wr_acked_q     <= wr_acked_d;
      rd_req_valid_q <= rd_req_valid_d;
      rd_req_addr_q  <= rd_req_addr_d;
      rd_req_mdata_q <= rd_req_mdata_d;
      wr_req_valid_q <= wr_req_valid_d;
      wr_req_addr_q  <= wr_req_addr_d;
      wr_req_data_q  <= wr_req_data_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
    end
  end

  assign bus.rd_req_valid = rd_req_valid_q;
  assign bus.rd_req_addr  = rd_req_addr_q;
  assign bus.rd_req_mdata = rd_req_mdata_q;
  assign bus.wr_req_valid = wr_req_valid_q;
  assign bus.wr_req_addr  = wr_req_addr_q;
  assign bus.wr_req_data  = wr_req_data_q;
  assign busy             = busy_q;
  assign done             = done_q;

  // The read credit limit must keep the response FIFO from ever overflowing
  a_fifo_no_overflow: assert property (@(posedge clk) disable iff (reset)
    !(fifo_push && fifo_full && !fifo_pop) && (fifo_count <= FCW'(MAX_OUTSTANDING)));

endmodule

// File: tb/tb_hc_stream_ctrl.sv
// Directed bench for hc_stream_ctrl: a table of single-run transfers plus
// hand-written sequences for reordering, credit stall, backpressure and reset.
module tb_hc_stream_ctrl;

  localparam int unsigned ADDR_W = 42;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [ADDR_W-1:0] cfg_src_addr = '0, cfg_dst_addr = '0, cfg_dsm_addr = '0;
  logic [15:0]       cfg_num_lines = '0;
  logic              cfg_start = 1'b0, cfg_stop = 1'b0;
  logic              busy, done;

  hc_stream_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

  hc_stream_ctrl #(
    .MAX_OUTSTANDING (8),
    .ADD_CONST       (32'd10),
    .ADDR_W          (ADDR_W)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .cfg_src_addr  (cfg_src_addr),
    .cfg_dst_addr  (cfg_dst_addr),
    .cfg_dsm_addr  (cfg_dsm_addr),
    .cfg_num_lines (cfg_num_lines),
    .cfg_start     (cfg_start),
    .cfg_stop      (cfg_stop),
    .bus           (bus),
    .busy          (busy),
    .done          (done)
  );

  always #5 clk = ~clk;

  typedef struct { logic [ADDR_W-1:0] addr; logic [15:0] tag; } rd_t;
  typedef struct { logic [ADDR_W-1:0] addr; logic [511:0] data; } wr_t;

  rd_t rd_log[$];
  wr_t wr_log[$];
  int  n_wr = 0;

  // Request log, sampled mid-cycle
  always @(negedge clk) begin
    if (bus.rd_req_valid) rd_log.push_back('{bus.rd_req_addr, bus.rd_req_mdata});
    if (bus.wr_req_valid) begin
      wr_log.push_back('{bus.wr_req_addr, bus.wr_req_data});
      n_wr++;
    end
  end

  int          checks = 0, failures = 0;
  bit          auto_rd = 1'b1, auto_ack = 1'b1;
  int          rd_served = 0, acks_sent = 0;
  logic [31:0] lane_base = '0, lane_inc = '0;

  function automatic logic [511:0] src_line(input logic [15:0] tag);
    logic [511:0] r;
    for (int j = 0; j < 16; j++) r[32*j +: 32] = lane_base + lane_inc * (32'(tag) * 32'd16 + 32'(j));
    return r;
  endfunction

  function automatic logic [511:0] exp_line(input logic [15:0] tag);
    logic [511:0] r;
    logic [31:0]  v;
    for (int j = 0; j < 16; j++) begin
      v = lane_base + lane_inc * (32'(tag) * 32'd16 + 32'(j));
      r[32*j +: 32] = v + 32'd10;
    end
    return r;
  endfunction

  task automatic chk_w(input string name, input logic [511:0] got, input logic [511:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic chk_i(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic get_wr(input int idx, output logic [ADDR_W-1:0] a, output logic [511:0] d);
    if (idx < wr_log.size()) begin a = wr_log[idx].addr; d = wr_log[idx].data; end
    else begin a = 'x; d = 'x; end
  endtask

  task automatic get_rd(input int idx, output logic [ADDR_W-1:0] a, output logic [15:0] t);
    if (idx < rd_log.size()) begin a = rd_log[idx].addr; t = rd_log[idx].tag; end
    else begin a = 'x; t = 'x; end
  endtask

  // One clock; then the automatic read responder and write acker act
  task automatic cycle();
    @(posedge clk);
    #1;
    if (auto_rd) begin
      if (rd_served < rd_log.size()) begin
        bus.rd_rsp_valid = 1'b1;
        bus.rd_rsp_mdata = rd_log[rd_served].tag;
        bus.rd_rsp_data  = src_line(rd_log[rd_served].tag);
        rd_served++;
      end else bus.rd_rsp_valid = 1'b0;
    end
    if (auto_ack) begin
      if (acks_sent < n_wr) begin bus.wr_rsp_valid = 1'b1; acks_sent++; end
      else bus.wr_rsp_valid = 1'b0;
    end
  endtask

  task automatic start(input logic [15:0] n, input logic [ADDR_W-1:0] s, d, m);
    cfg_num_lines = n; cfg_src_addr = s; cfg_dst_addr = d; cfg_dsm_addr = m;
    cfg_start = 1'b1;
    cycle();
    cfg_start = 1'b0;
  endtask

  task automatic stop_run();
    cfg_stop = 1'b1;
    cycle();
    cfg_stop = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    for (int k = 0; k < budget && done !== 1'b1; k++) cycle();
    chk_i(name, int'(done === 1'b1), 1);
    cycle();  // let the log capture the flag write issued with done
  endtask

  task automatic manual_rsp(input logic [15:0] tag);
    bus.rd_rsp_valid = 1'b1;
    bus.rd_rsp_mdata = tag;
    bus.rd_rsp_data  = src_line(tag);
    cycle();
    bus.rd_rsp_valid = 1'b0;
  endtask

  typedef struct {
    logic [15:0]       num;
    logic [ADDR_W-1:0] src, dst, dsm;
    logic [31:0]       lane;
    logic [ADDR_W-1:0] rd_first, rd_last, wr_last;
    logic [31:0]       lane_out;
    logic [ADDR_W-1:0] flag_addr;
    int                n_rd, n_wr;
  } vec_t;

  initial begin
    vec_t              vecs[4];
    int                rd0, wr0, viol, wr_before, rd_before;
    logic [ADDR_W-1:0] a;
    logic [511:0]      d;
    logic [15:0]       t;
    logic [31:0]       lane;
    int                ooo[4];
    bit                seen;

    vecs[0] = '{16'd1, 42'h100, 42'h200, 42'h300, 32'h5,
                42'h100, 42'h100, 42'h200, 32'hF, 42'h301, 1, 2};
    vecs[1] = '{16'd2, 42'h3FF_FFFF_FFFF, 42'h3FF_FFFF_FFFE, 42'h3FF_FFFF_FFFF, 32'hFFFF_FFFA,
                42'h3FF_FFFF_FFFF, 42'h0, 42'h3FF_FFFF_FFFF, 32'h4, 42'h0, 2, 3};
    vecs[2] = '{16'd3, 42'h1000, 42'h2000, 42'h40, 32'h1234_5678,
                42'h1000, 42'h1002, 42'h2002, 32'h1234_5682, 42'h41, 3, 4};
    vecs[3] = '{16'd0, 42'h10, 42'h20, 42'h30, 32'h0,
                42'h0, 42'h0, 42'h0, 32'h0, 42'h31, 0, 1};
    ooo = '{3, 1, 0, 2};

    bus.c0_alm_full = 1'b0; bus.c1_alm_full = 1'b0;
    bus.rd_rsp_valid = 1'b0; bus.rd_rsp_mdata = '0; bus.rd_rsp_data = '0;
    bus.wr_rsp_valid = 1'b0;

    repeat (3) cycle();
    chk_i("reset_rd_req_valid", int'(bus.rd_req_valid), 0);
    chk_i("reset_wr_req_valid", int'(bus.wr_req_valid), 0);
    chk_i("reset_busy", int'(busy), 0);
    chk_i("reset_done", int'(done), 0);
    reset = 1'b0;
    cycle();

    // Table: in-order responses, uniform lane values
    for (int i = 0; i < 4; i++) begin
      rd0 = rd_log.size(); wr0 = wr_log.size();
      lane_base = vecs[i].lane; lane_inc = '0;
      start(vecs[i].num, vecs[i].src, vecs[i].dst, vecs[i].dsm);
      chk_i($sformatf("v%0d_busy", i), int'(busy), 1);
      wait_done($sformatf("v%0d_done", i), 200);
      chk_i($sformatf("v%0d_nrd", i), rd_log.size() - rd0, vecs[i].n_rd);
      chk_i($sformatf("v%0d_nwr", i), wr_log.size() - wr0, vecs[i].n_wr);
      if (vecs[i].num != 16'd0) begin
        get_rd(rd0, a, t);
        chk_w($sformatf("v%0d_rd_first", i), 512'(a), 512'(vecs[i].rd_first));
        chk_w($sformatf("v%0d_rd_tag0", i), 512'(t), 512'(0));
        get_rd(rd0 + int'(vecs[i].num) - 1, a, t);
        chk_w($sformatf("v%0d_rd_last", i), 512'(a), 512'(vecs[i].rd_last));
        get_wr(wr0 + int'(vecs[i].num) - 1, a, d);
        chk_w($sformatf("v%0d_wr_addr", i), 512'(a), 512'(vecs[i].wr_last));
        chk_w($sformatf("v%0d_wr_data", i), d, {16{vecs[i].lane_out}});
      end
      get_wr(wr0 + int'(vecs[i].num), a, d);
      chk_w($sformatf("v%0d_flag_addr", i), 512'(a), 512'(vecs[i].flag_addr));
      chk_w($sformatf("v%0d_flag_data", i), d, 512'h1);
      stop_run();
      chk_i($sformatf("v%0d_stop_done", i), int'(done), 0);
    end

    // Out-of-order responses 3,1,0,2
    rd0 = rd_log.size(); wr0 = wr_log.size();
    lane_base = 32'hFFFF_FFF0; lane_inc = 32'd1; auto_rd = 1'b0;
    start(16'd4, 42'h500, 42'h600, 42'h700);
    for (int k = 0; k < 20 && (rd_log.size() - rd0) < 4; k++) cycle();
    chk_i("ooo_nrd", rd_log.size() - rd0, 4);
    for (int k = 0; k < 4; k++) begin
      get_rd(rd0 + k, a, t);
      chk_w($sformatf("ooo_rd%0d_addr", k), 512'(a), 512'(42'h500 + 42'(k)));
      chk_w($sformatf("ooo_rd%0d_tag", k), 512'(t), 512'(k));
    end
    for (int k = 0; k < 4; k++) manual_rsp(16'(ooo[k]));
    wait_done("ooo_done", 100);
    for (int k = 0; k < 4; k++) begin
      get_wr(wr0 + k, a, d);
      chk_w($sformatf("ooo_wr%0d_addr", k), 512'(a), 512'(42'h600 + 42'(ooo[k])));
      chk_w($sformatf("ooo_wr%0d_data", k), d, exp_line(16'(ooo[k])));
    end
    get_wr(wr0 + 2, a, d);
    lane = d[32*10 +: 32];
    chk_w("ooo_lane_wrap", 512'(lane), 512'(32'h4));
    get_wr(wr0 + 4, a, d);
    chk_w("ooo_flag_addr", 512'(a), 512'(42'h701));
    stop_run();
    rd_served = rd_log.size();

    // Credit limit: 20 lines with responses withheld
    rd0 = rd_log.size(); wr0 = wr_log.size();
    lane_base = '0; lane_inc = 32'd1;
    start(16'd20, 42'h1000, 42'h2000, 42'h3000);
    repeat (30) cycle();
    chk_i("credit_stall_nrd", rd_log.size() - rd0, 8);
    chk_i("credit_stall_nwr", wr_log.size() - wr0, 0);
    manual_rsp(16'd0);
    repeat (10) cycle();
    chk_i("credit_release_nrd", rd_log.size() - rd0, 9);
    chk_i("credit_release_nwr", wr_log.size() - wr0, 1);
    rd_served = rd0 + 1; auto_rd = 1'b1;
    wait_done("credit_done", 400);
    chk_i("credit_total_nrd", rd_log.size() - rd0, 20);
    chk_i("credit_total_nwr", wr_log.size() - wr0, 21);
    get_wr(wr0 + 20, a, d);
    chk_w("credit_flag_addr", 512'(a), 512'(42'h3001));
    stop_run();

    // Write backpressure for 50 cycles during an 8-line run
    rd0 = rd_log.size(); wr0 = wr_log.size();
    lane_base = 32'h100; lane_inc = 32'd1;
    bus.c1_alm_full = 1'b1;
    start(16'd8, 42'h4000, 42'h5000, 42'h6000);
    viol = 0;
    for (int k = 0; k < 50; k++) begin
      cycle();
      if (bus.wr_req_valid) viol++;
    end
    chk_i("bp_no_write_while_full", viol, 0);
    chk_i("bp_nrd", rd_log.size() - rd0, 8);
    chk_i("bp_fifo_count", int'(dut.fifo_count), 8);
    bus.c1_alm_full = 1'b0;
    wait_done("bp_done", 100);
    chk_i("bp_nwr", wr_log.size() - wr0, 9);
    for (int k = 0; k < 8; k++) begin
      get_wr(wr0 + k, a, d);
      chk_w($sformatf("bp_wr%0d_data", k), d, exp_line(16'(a - 42'h5000)));
    end
    stop_run();

    // Zero lines: flag write within 3 cycles of start
    rd0 = rd_log.size();
    start(16'd0, 42'h70, 42'h80, 42'h90);
    seen = 1'b0;
    for (int k = 0; k < 3 && !seen; k++) begin
      cycle();
      if (bus.wr_req_valid) begin
        seen = 1'b1;
        chk_w("zero_flag_addr", 512'(bus.wr_req_addr), 512'(42'h91));
        chk_w("zero_flag_data", bus.wr_req_data, 512'h1);
      end
    end
    chk_i("zero_flag_seen", int'(seen), 1);
    wait_done("zero_done", 10);
    chk_i("zero_nrd", rd_log.size() - rd0, 0);
    stop_run();
    chk_i("zero_stop_done", int'(done), 0);
    chk_i("zero_stop_busy", int'(busy), 0);

    // Reset mid-transfer, then stale responses, then a clean run
    rd0 = rd_log.size();
    auto_rd = 1'b0;
    start(16'd10, 42'h8000, 42'h9000, 42'hA000);
    for (int k = 0; k < 20 && (rd_log.size() - rd0) < 3; k++) cycle();
    reset = 1'b1;
    cycle();
    chk_i("abort_rd_req_valid", int'(bus.rd_req_valid), 0);
    chk_i("abort_wr_req_valid", int'(bus.wr_req_valid), 0);
    chk_i("abort_busy", int'(busy), 0);
    chk_i("abort_done", int'(done), 0);
    reset = 1'b0;
    auto_ack = 1'b0;
    bus.wr_rsp_valid = 1'b1;
    manual_rsp(16'd1);
    bus.wr_rsp_valid = 1'b0;
    wr_before = wr_log.size(); rd_before = rd_log.size();
    repeat (10) cycle();
    chk_i("stale_no_write", wr_log.size() - wr_before, 0);
    chk_i("stale_no_read", rd_log.size() - rd_before, 0);
    chk_i("stale_busy", int'(busy), 0);
    rd_served = rd_log.size(); acks_sent = n_wr;
    auto_rd = 1'b1; auto_ack = 1'b1;
    rd0 = rd_log.size(); wr0 = wr_log.size();
    lane_base = 32'h7; lane_inc = '0;
    start(16'd2, 42'hB000, 42'hC000, 42'hD000);
    wait_done("clean_done", 100);
    chk_i("clean_nrd", rd_log.size() - rd0, 2);
    chk_i("clean_nwr", wr_log.size() - wr0, 3);
    get_wr(wr0, a, d);
    chk_w("clean_wr0_addr", 512'(a), 512'(42'hC000));
    chk_w("clean_wr0_data", d, {16{32'h11}});
    get_wr(wr0 + 1, a, d);
    chk_w("clean_wr1_addr", 512'(a), 512'(42'hC001));
    get_wr(wr0 + 2, a, d);
    chk_w("clean_flag_addr", 512'(a), 512'(42'hD001));
    stop_run();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
